// File: rtl/instruction_pkg.sv
// Shared RV32 instruction encodings and the M-extension execute-unit state type.
// The muldiv_unit FAST_MUL_EN macro selects its multiplier flavour; nothing here depends on it.
package instruction_pkg;

    // funct7 value that marks an OP-class instruction as RV32M
    localparam logic [6:0] MULDIV_7 = 7'b0000001;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Handshake state of the multiply/divide unit, visible to trace/debug in other stages
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // funct3[2] separates the divide class from the multiply class
    function automatic logic is_div_op(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath for muldiv_unit: one restoring-divide or shift-add multiply step per
// cycle on unsigned magnitudes, 2*XLEN-bit accumulator, 6-bit step counter.
// step_acc is the accumulator value being written this cycle, so the caller can capture
// the final result on the same edge that performs the last step (done high).
module muldiv_iter_core
    import instruction_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              start,
    input  logic              is_div,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic              done,
    output logic [2*XLEN-1:0] step_acc
);

    localparam logic [5:0] LAST = 6'(XLEN - 1);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand;
    logic [5:0]        count;
    logic              busy;
    logic              div_mode;

    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN:0]     sum;

    // One divide or multiply step from the current accumulator
    always_comb begin
        // Divide: acc = {remainder, dividend/quotient}; shift one dividend bit into the remainder
        rem_sh = acc[2*XLEN-1:XLEN-1];
        rem_ge = rem_sh >= {1'b0, operand};
        // Multiply: acc = {partial high, multiplier}; add multiplicand when LSB set, then shift right
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        if (div_mode) begin
            if (rem_ge) begin
                step_acc = {rem_sh[XLEN-1:0] - operand, acc[XLEN-2:0], 1'b1};
            end else begin
                step_acc = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end
        end else begin
            step_acc = {sum, acc[XLEN-1:1]};
        end
        done = busy && (count == LAST);
    end

    // Load operands on start, then step until the counter reaches the last iteration
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            acc      <= '0;
            operand  <= '0;
            count    <= '0;
            busy     <= 1'b0;
            div_mode <= 1'b0;
        end else if (start) begin
            acc      <= is_div ? {{XLEN{1'b0}}, op_a} : {{XLEN{1'b0}}, op_b};
            operand  <= is_div ? op_b : op_a;
            count    <= '0;
            busy     <= 1'b1;
            div_mode <= is_div;
        end else if (busy) begin
            acc   <= step_acc;
            count <= count + 6'd1;
            if (count == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle execute unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with
// valid/ready request and response handshakes and a pipeline flush (kill).
// Build option FAST_MUL_EN: multiply class uses a registered single-cycle 33x33 multiply
// instead of the shared iterative core.
module muldiv_unit
    import instruction_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            kill,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic [4:0]      resp_rd
);

`ifdef FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    muldiv_state_t     state_q, state_d;
    logic              accept;
    logic              core_start;
    logic              core_done;
    logic [2*XLEN-1:0] core_acc;

    logic [2:0]        funct3_q;
    logic              negate_q;

    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_result;
    logic              negate_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_result;

    // Request decode: operand signedness, magnitudes and divide special cases
    always_comb begin
        a_signed = (req_funct3 == F3_MULH) || (req_funct3 == F3_MULHSU) ||
                   (req_funct3 == F3_DIV)  || (req_funct3 == F3_REM);
        b_signed = (req_funct3 == F3_MULH) || (req_funct3 == F3_DIV) || (req_funct3 == F3_REM);
        sign_a   = a_signed & req_rs1[XLEN-1];
        sign_b   = b_signed & req_rs2[XLEN-1];
        mag_a    = sign_a ? -req_rs1 : req_rs1;
        mag_b    = sign_b ? -req_rs2 : req_rs2;
        div_zero = is_div_op(req_funct3) && (req_rs2 == '0);
        div_ovf  = ((req_funct3 == F3_DIV) || (req_funct3 == F3_REM)) &&
                   (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
        special  = div_zero || div_ovf;
        // funct3[1] distinguishes REM* from DIV*
        if (div_zero) begin
            special_result = req_funct3[1] ? req_rs1 : '1;
        end else begin
            special_result = req_funct3[1] ? '0 : req_rs1;
        end
        case (req_funct3)
            F3_DIV, F3_MULH, F3_MULHSU: negate_d = sign_a ^ sign_b;
            F3_REM:                     negate_d = sign_a;
            default:                    negate_d = 1'b0;
        endcase
    end

`ifdef FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]          fast_result;

    // Single-cycle signed 33x33 multiply on sign-extended operands
    always_comb begin
        fast_a      = {a_signed & req_rs1[XLEN-1], req_rs1};
        fast_b      = {b_signed & req_rs2[XLEN-1], req_rs2};
        fast_prod   = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
        fast_result = (req_funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Sign fix-up of the iterative core's final step; MUL never negates, so prod_fix serves it too
    always_comb begin
        prod_fix = negate_q ? -core_acc : core_acc;
        case (funct3_q)
            F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_result = negate_q ? -core_acc[XLEN-1:0]
                                                                : core_acc[XLEN-1:0];
            default:                      fix_result = negate_q ? -core_acc[2*XLEN-1:XLEN]
                                                                : core_acc[2*XLEN-1:XLEN];
        endcase
    end

    // Handshake FSM next state; kill overrides every transition
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        req_ready  = (state_q == IDLE) && !kill;
        accept     = req_valid && req_ready;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (special || (FAST_MUL && !is_div_op(req_funct3))) begin
                        state_d = DONE;
                    end else begin
                        state_d    = BUSY;
                        core_start = 1'b1;
                    end
                end
            end
            BUSY:    if (core_done)  state_d = DONE;
            DONE:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_result <= '0;
            resp_rd     <= '0;
            funct3_q    <= '0;
            negate_q    <= 1'b0;
        end else if (accept) begin
            resp_rd  <= req_rd;
            funct3_q <= req_funct3;
            negate_q <= negate_d;
            if (special) begin
                resp_result <= special_result;
            end
`ifdef FAST_MUL_EN
            else if (!is_div_op(req_funct3)) begin
                resp_result <= fast_result;
            end
`endif
        end else if ((state_q == BUSY) && core_done && !kill) begin
            resp_result <= fix_result;
        end
    end

    assign resp_valid = (state_q == DONE);

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .abort    (kill),
        .start    (core_start),
        .is_div   (is_div_op(req_funct3)),
        .op_a     (mag_a),
        .op_b     (mag_b),
        .done     (core_done),
        .step_acc (core_acc)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit: directed RV32M vectors with hand-computed results,
// latency checks, response backpressure and kill of an in-flight divide.
module tb_muldiv_unit;
    import instruction_pkg::*;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset, kill, req_valid, req_ready, resp_valid, resp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2, resp_result;
    logic [4:0]  req_rd, resp_rd;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   lat_done = 1'b0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .kill        (kill),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_rd     (resp_rd)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request at a negedge once req_ready is seen; optionally record its expectation
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat,
                         input bit track);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready=0, expected 1 within 300 cycles");
            return;
        end
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        if (track) begin
            e.result  = res;
            e.rd      = rd;
            e.lat     = lat;
            e.acc_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_rs1    = $urandom;
        req_rs2    = $urandom;
        req_rd     = 5'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
        end
    endtask

    // Monitor: latency on first resp_valid, result/rd on handshake
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 result=0x%08h, expected no response",
                         resp_result);
            end else begin
                if (!lat_done) begin
                    check("latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(sb[0].lat));
                    lat_done = 1'b1;
                end
                if (resp_ready) begin
                    check("resp_result", resp_result, sb[0].result);
                    check("resp_rd", 32'(resp_rd), 32'(sb[0].rd));
                    void'(sb.pop_front());
                    lat_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;
        reset      = 1'b1;
        kill       = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_rd     = '0;
        resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_result", resp_result, 32'd0);
        check("reset_resp_rd", 32'(resp_rd), 32'd0);
        reset = 1'b0;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);

        issue(F3_DIV,    32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFD, DIV_LAT, 1);
        issue(F3_REM,    32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF, DIV_LAT, 1);
        issue(F3_DIVU,   32'd100,       32'd0,        5'd7,  32'hFFFF_FFFF, 1,       1);
        issue(F3_REMU,   32'd100,       32'd0,        5'd8,  32'd100,       1,       1);
        issue(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1,       1);
        issue(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0,         1,       1);
        issue(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, MUL_LAT, 1);
        issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, MUL_LAT, 1);
        issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE, MUL_LAT, 1);
        issue(F3_MUL,    32'hFFFF_FFFD, 32'd7,        5'd14, 32'hFFFF_FFEB, MUL_LAT, 1);
        issue(F3_DIVU,   32'd1000,      32'd7,        5'd15, 32'd142,       DIV_LAT, 1);
        issue(F3_REMU,   32'd1000,      32'd7,        5'd16, 32'd6,         DIV_LAT, 1);
        issue(F3_DIV,    32'd7,         32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, DIV_LAT, 1);
        issue(F3_REM,    32'd7,         32'hFFFF_FFFE, 5'd18, 32'd1,         DIV_LAT, 1);
        drain();

        // Backpressure: hold resp_ready low for 10 cycles in DONE
        @(negedge clk);
        resp_ready = 1'b0;
        issue(F3_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, DIV_LAT, 1);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_result", resp_result, 32'd14);
            check("bp_resp_rd", 32'(resp_rd), 32'd3);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        drain();

        // Kill a DIVU around its 15th iteration
        issue(F3_DIVU, 32'h0000_FFFF, 32'd3, 5'd20, 32'd0, DIV_LAT, 0);
        repeat (14) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        #1;
        check("kill_resp_valid", 32'(resp_valid), 32'd0);
        check("kill_req_ready", 32'(req_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("kill_no_resp", 32'(seen), 32'd0);
        issue(F3_MUL, 32'd3, 32'd4, 5'd21, 32'd12, MUL_LAT, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
